// File: rtl/flag_pkg.sv
// flag_pkg: opcode, condition-code and flag-index constants plus condition evaluation
package flag_pkg;
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_CMP = 11;
    localparam logic [2:0] CC_AL = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GE = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_NE = 3'b100;
    localparam logic [2:0] CC_CS = 3'b101;
    localparam logic [2:0] CC_CC = 3'b110;
    localparam logic [2:0] CC_GT = 3'b111;
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[FLG_N];
        z = f[FLG_Z];
        c = f[FLG_C];
        v = f[FLG_V];
        return cc == CC_AL ? 1'b1 :
               cc == CC_EQ ? z :
               cc == CC_GE ? n == v :
               cc == CC_LT ? n != v :
               cc == CC_NE ? !z :
               cc == CC_CS ? c :
               cc == CC_CC ? !c :
               !z && (n == v);
    endfunction
endpackage

// File: rtl/flag_stack.sv
// flag_stack: LIFO of 4-bit flag snapshots with occupancy count and sticky misuse error
module flag_stack #(
    parameter int STK_DEPTH = 4,
    localparam int PW = $clog2(STK_DEPTH + 1),
    localparam int AW = $clog2(STK_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [3:0]    din,
    output logic [3:0]    dout,
    output logic          pop_ok,
    output logic [PW-1:0] cnt,
    output logic          full,
    output logic          empty,
    output logic          err
);
    logic [3:0] mem [STK_DEPTH];
    logic [PW-1:0] top_idx;
    logic push_ok;

    assign full    = cnt == PW'(STK_DEPTH);
    assign empty   = cnt == '0;
    assign push_ok = push && !pop && !full;
    assign pop_ok  = pop && !push && !empty;
    assign top_idx = cnt - PW'(1);
    assign dout    = mem[top_idx[AW-1:0]];

    always_ff @(posedge clk)
        if (push_ok) mem[cnt[AW-1:0]] <= din;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= push_ok ? cnt + PW'(1) : pop_ok ? top_idx : cnt;
            if ((push && pop) || (push && full) || (pop && empty)) err <= 1'b1;
        end
endmodule

// File: rtl/flag_unit.sv
// flag_unit: registered NZCV flags with conditional update, condition evaluation and interrupt flag stack
module flag_unit
    import flag_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W = 4,
    parameter int STK_DEPTH = 4,
    localparam int PW = $clog2(STK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [OP_W-1:0]   opcode,
    input  logic [2:0]        cond,
    input  logic [DATA_W-1:0] result,
    input  logic              ovf_add,
    input  logic              c_add,
    input  logic              ovf_sub,
    input  logic              c_sub,
    input  logic              flag_push,
    input  logic              flag_pop,
    output logic              cond_pass,
    output logic              wb_en,
    output logic [3:0]        flags_q,
    output logic [PW-1:0]     stk_cnt,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);
    logic is_add, is_sub, is_mul, is_cmp, upd;
    logic pop_ok;
    logic [3:0] alu_flags, stk_dout;

    assign is_add    = opcode == OP_W'(OP_ADD);
    assign is_sub    = opcode == OP_W'(OP_SUB);
    assign is_mul    = opcode == OP_W'(OP_MUL);
    assign is_cmp    = opcode == OP_W'(OP_CMP);
    assign cond_pass = cond_eval(cond, flags_q);
    assign upd       = alu_valid && cond_pass && (is_add || is_sub || is_mul || is_cmp);
    assign wb_en     = alu_valid && cond_pass && !is_cmp;
    // MUL only touches N/Z; C/V hold their previous values
    assign alu_flags = {result[DATA_W-1], result == '0,
                        is_add ? {c_add, ovf_add} : (is_sub || is_cmp) ? {c_sub, ovf_sub} : flags_q[1:0]};

    always_ff @(posedge clk or posedge rst)
        if (rst) flags_q <= '0;
        else flags_q <= pop_ok ? stk_dout : upd ? alu_flags : flags_q;

    flag_stack #(.STK_DEPTH(STK_DEPTH)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (flag_push),
        .pop   (flag_pop),
        .din   (flags_q),
        .dout  (stk_dout),
        .pop_ok(pop_ok),
        .cnt   (stk_cnt),
        .full  (stk_full),
        .empty (stk_empty),
        .err   (stk_err)
    );
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed scoreboard bench for flag_unit
module tb_flag_unit;
    logic clk, rst, alu_valid, ovf_add, c_add, ovf_sub, c_sub, flag_push, flag_pop;
    logic [3:0] opcode;
    logic [2:0] cond;
    logic [15:0] result;
    logic cond_pass, wb_en, stk_full, stk_empty, stk_err;
    logic [3:0] flags_q;
    logic [2:0] stk_cnt;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        logic [3:0] f;
        logic [2:0] cnt;
        logic err;
    } exp_t;
    exp_t q[$];

    flag_unit dut (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .opcode(opcode), .cond(cond), .result(result),
        .ovf_add(ovf_add), .c_add(c_add), .ovf_sub(ovf_sub), .c_sub(c_sub),
        .flag_push(flag_push), .flag_pop(flag_pop), .cond_pass(cond_pass), .wb_en(wb_en),
        .flags_q(flags_q), .stk_cnt(stk_cnt), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] cc, input logic [15:0] res,
                         input logic oa, input logic ca, input logic os, input logic cs,
                         input logic ps, input logic pp);
        alu_valid = v; opcode = op; cond = cc; result = res;
        ovf_add = oa; c_add = ca; ovf_sub = os; c_sub = cs;
        flag_push = ps; flag_pop = pp;
    endtask

    task automatic comb(input string tag, input logic cp, input logic wb);
        #1;
        chk({tag, "_cond_pass"}, {7'd0, cond_pass}, {7'd0, cp});
        chk({tag, "_wb_en"}, {7'd0, wb_en}, {7'd0, wb});
    endtask

    task automatic step(input string tag, input logic [3:0] f, input logic [2:0] cnt, input logic err);
        exp_t e;
        q.push_back('{tag, f, cnt, err});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({e.tag, "_flags"}, {4'd0, flags_q}, {4'd0, e.f});
        chk({e.tag, "_cnt"}, {5'd0, stk_cnt}, {5'd0, e.cnt});
        chk({e.tag, "_err"}, {7'd0, stk_err}, {7'd0, e.err});
        chk({e.tag, "_full"}, {7'd0, stk_full}, {7'd0, e.cnt == 3'd4});
        chk({e.tag, "_empty"}, {7'd0, stk_empty}, {7'd0, e.cnt == 3'd0});
    endtask

    initial begin
        logic [7:0] cc_tab;
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 0;
        chk("rst_flags", {4'd0, flags_q}, 8'h00);
        chk("rst_cnt", {5'd0, stk_cnt}, 8'h00);
        chk("rst_empty", {7'd0, stk_empty}, 8'h01);
        chk("rst_full", {7'd0, stk_full}, 8'h00);
        chk("rst_err", {7'd0, stk_err}, 8'h00);
        // ADD then SUB source selection
        drive(1, 0, 3'd0, 16'h8000, 1, 0, 0, 0, 0, 0); comb("add", 1, 1);
        step("add_neg_ovf", 4'b1001, 0, 0);
        drive(1, 1, 3'd0, 16'h0000, 0, 0, 0, 1, 0, 0); comb("sub", 1, 1);
        step("sub_zero", 4'b0110, 0, 0);
        // MUL keeps C/V; undefined opcode has no flag effect
        drive(1, 2, 3'd0, 16'h0005, 1, 0, 1, 0, 0, 0); step("mul_keep_cv", 4'b0010, 0, 0);
        drive(0, 0, 3'd7, 16'h0000, 0, 0, 0, 0, 0, 0); comb("gt_true", 1, 0);
        drive(1, 5, 3'd0, 16'h0000, 1, 1, 1, 1, 0, 0); comb("op5", 1, 1);
        step("op5_no_change", 4'b0010, 0, 0);
        // condition gating
        drive(1, 1, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 0); step("sub_z", 4'b0100, 0, 0);
        drive(1, 0, 3'd4, 16'h0001, 0, 0, 0, 0, 0, 0); comb("ne_fail", 0, 0);
        step("ne_fail", 4'b0100, 0, 0);
        drive(1, 0, 3'd1, 16'h8000, 0, 1, 0, 0, 0, 0); comb("eq_pass", 1, 1);
        step("eq_pass", 4'b1010, 0, 0);
        drive(1, 11, 3'd0, 16'h0000, 0, 0, 1, 1, 0, 0); comb("cmp", 1, 0);
        step("cmp", 4'b0111, 0, 0);
        // all condition codes against N=0 Z=1 C=1 V=1
        cc_tab = 8'b0010_1011;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 3'(i), 16'h0000, 0, 0, 0, 0, 0, 0);
            comb($sformatf("cc%0d", i), cc_tab[i], 0);
        end
        step("invalid_no_upd", 4'b0111, 0, 0);
        // push with concurrent ALU update, then pop overriding ALU
        drive(1, 0, 3'd0, 16'h8000, 0, 1, 0, 0, 0, 0); step("set_1010", 4'b1010, 0, 0);
        drive(1, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 0); step("push_alu", 4'b0100, 1, 0);
        drive(1, 0, 3'd0, 16'h0001, 0, 0, 0, 0, 0, 1); step("pop_override", 4'b1010, 0, 0);
        // fill, overflow, LIFO drain, underflow
        drive(1, 0, 3'd0, 16'h0001, 0, 0, 0, 0, 1, 0); step("push1", 4'b0000, 1, 0);
        drive(1, 1, 3'd0, 16'h8000, 0, 0, 1, 1, 1, 0); step("push2", 4'b1011, 2, 0);
        drive(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 0); step("push3", 4'b1011, 3, 0);
        step("push4_full", 4'b1011, 4, 0);
        step("push_on_full", 4'b1011, 4, 1);
        drive(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 1); step("pop4", 4'b1011, 3, 1);
        step("pop3", 4'b1011, 2, 1);
        step("pop2", 4'b0000, 1, 1);
        step("pop1", 4'b1010, 0, 1);
        step("pop_on_empty", 4'b1010, 0, 1);
        // async reset mid-cycle
        drive(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 0); step("pre_push1", 4'b1010, 1, 1);
        step("pre_push2", 4'b1010, 2, 1);
        drive(0, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 0);
        #2 rst = 1;
        #1;
        chk("arst_flags", {4'd0, flags_q}, 8'h00);
        chk("arst_cnt", {5'd0, stk_cnt}, 8'h00);
        chk("arst_empty", {7'd0, stk_empty}, 8'h01);
        chk("arst_err", {7'd0, stk_err}, 8'h00);
        @(posedge clk);
        #1 rst = 0;
        // push and pop together: stack ignored, ALU still applies
        drive(1, 0, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 1); step("push_pop", 4'b0100, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
